uart_rx_ctrl: RTL and testbench

Parametrised UART receive controller, the next generation of the receiver FSM. It is driven by a 16x oversample tick, runs in the rx_clk domain and contains its own synchroniser and mid-bit sampler. Supported framing: DATA_WIDTH data bits, LSB first; runtime-selectable parity (none/even/odd); 1 or 2 stop bits. It returns bytes over a valid/ready handshake with parity, framing, break and overrun status, and sits between the pad and the receive FIFO.

---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_sync_ff.sv | 24 ++
 rtl/uart_rx_ctrl.sv | 213 +++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, parity modes and sample-point helper.
// The 3-bit state encoding is shared with the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_START     = 3'd1,
        ST_DATA      = 3'd2,
        ST_PARITY    = 3'd3,
        ST_STOP1     = 3'd4,
        ST_STOP2     = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } uart_state_e;

    typedef enum logic [1:0] {
        PARITY_NONE = 2'd0,
        PARITY_EVEN = 2'd1,
        PARITY_ODD  = 2'd2
    } uart_parity_e;

    // Tick index at which the middle of a bit period is reached.
    function automatic int mid_sample_idx(input int oversample);
        return oversample / 2 - 1;
    endfunction

endpackage

// File: rtl/uart_sync_ff.sv
// Multi-flop synchroniser for an asynchronous, idle-high serial line.
// Resets to 1 so a line in reset never looks like a start bit.
module uart_sync_ff #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic resetn,
    input  logic d,
    output logic q
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sync_q <= '1;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d};
        end
    end

    assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive controller: oversampled mid-bit sampler, runtime parity/stop framing,
// and a held valid/ready output with parity, framing, break and overrun status.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH  = 8,
    parameter int OVERSAMPLE  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  rx_clk,
    input  logic                  resetn,
    input  logic                  baud_tick,
    input  logic                  rx_in,
    input  logic                  parity_en,
    input  logic                  parity_odd,
    input  logic                  two_stop,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    input  logic                  rx_ready,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  break_detect,
    output logic                  overrun,
    output logic                  busy
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_WIDTH);
    localparam logic [TICK_W-1:0] MID_TICK  = TICK_W'(mid_sample_idx(OVERSAMPLE));
    localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);

    logic [1:0]            rst_sync_q;
    logic                  rst_n;
    logic                  rx_sync;
    logic                  rx_prev_q;
    uart_state_e           state_q, state_d;
    logic [TICK_W-1:0]     tick_cnt_q;
    logic [BIT_W-1:0]      bit_cnt_q;
    logic [DATA_WIDTH-1:0] shift_q;
    logic                  par_bit_q;
    logic                  stop_err_q;
    uart_parity_e          par_mode_q;
    logic                  two_stop_q;
    logic                  start_det;
    logic                  sample;
    logic                  frame_done;
    logic                  fe_now, pe_now, brk_now;

    // Reset asserts immediately, releases synchronously to rx_clk.
    always_ff @(posedge rx_clk or negedge resetn) begin
        if (!resetn) begin
            rst_sync_q <= 2'b00;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end
    assign rst_n = rst_sync_q[1];

    uart_sync_ff #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (rx_clk),
        .resetn(rst_n),
        .d     (rx_in),
        .q     (rx_sync)
    );

    // Completion status, valid on the tick of the final stop sample.
    assign fe_now  = stop_err_q | ~rx_sync;
    assign pe_now  = (par_mode_q != PARITY_NONE) &
                     ((^shift_q) ^ par_bit_q ^ (par_mode_q == PARITY_ODD));
    assign brk_now = fe_now & (shift_q == '0) & ((par_mode_q == PARITY_NONE) | ~par_bit_q);
    assign busy    = (state_q != ST_IDLE);

    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        start_det  = 1'b0;
        sample     = 1'b0;
        frame_done = 1'b0;
        if (baud_tick) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_prev_q && !rx_sync) begin
                        start_det = 1'b1;
                        state_d   = ST_START;
                    end
                end
                ST_START: begin
                    if (tick_cnt_q == MID_TICK) begin
                        sample  = 1'b1;
                        state_d = rx_sync ? ST_IDLE : ST_DATA;
                    end
                end
                ST_DATA: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        sample = 1'b1;
                        if (bit_cnt_q == DATA_LAST) begin
                            state_d = (par_mode_q != PARITY_NONE) ? ST_PARITY : ST_STOP1;
                        end
                    end
                end
                ST_PARITY: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        sample  = 1'b1;
                        state_d = ST_STOP1;
                    end
                end
                ST_STOP1: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        sample = 1'b1;
                        if (two_stop_q) begin
                            state_d = ST_STOP2;
                        end else begin
                            frame_done = 1'b1;
                            state_d    = fe_now ? ST_WAIT_IDLE : ST_IDLE;
                        end
                    end
                end
                ST_STOP2: begin
                    if (tick_cnt_q == LAST_TICK) begin
                        sample     = 1'b1;
                        frame_done = 1'b1;
                        state_d    = fe_now ? ST_WAIT_IDLE : ST_IDLE;
                    end
                end
                ST_WAIT_IDLE: begin
                    if (rx_sync) begin
                        state_d = ST_IDLE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Sampling datapath; framing configuration is frozen at start detection.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_prev_q  <= 1'b1;
            tick_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            par_bit_q  <= 1'b0;
            stop_err_q <= 1'b0;
            par_mode_q <= PARITY_NONE;
            two_stop_q <= 1'b0;
        end else if (baud_tick) begin
            rx_prev_q <= rx_sync;
            if (start_det) begin
                tick_cnt_q <= '0;
                bit_cnt_q  <= '0;
                par_bit_q  <= 1'b0;
                stop_err_q <= 1'b0;
                par_mode_q <= parity_en ? (parity_odd ? PARITY_ODD : PARITY_EVEN) : PARITY_NONE;
                two_stop_q <= two_stop;
            end else if (sample) begin
                tick_cnt_q <= '0;
            end else begin
                tick_cnt_q <= tick_cnt_q + 1'b1;
            end
            if (sample) begin
                case (state_q)
                    ST_DATA: begin
                        shift_q   <= {rx_sync, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt_q <= bit_cnt_q + 1'b1;
                    end
                    ST_PARITY:          par_bit_q  <= rx_sync;
                    ST_STOP1, ST_STOP2: stop_err_q <= stop_err_q | ~rx_sync;
                    default: ;
                endcase
            end
        end
    end

    // Output holding register; a completed frame is dropped if the held word is not taken.
    always_ff @(posedge rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_detect <= 1'b0;
            overrun      <= 1'b0;
        end else if (frame_done) begin
            if (!rx_valid || rx_ready) begin
                rx_valid     <= 1'b1;
                rx_data      <= shift_q;
                parity_error <= pe_now;
                frame_error  <= fe_now;
                break_detect <= brk_now;
                overrun      <= 1'b0;
            end else begin
                overrun <= 1'b1;
            end
        end else if (rx_valid && rx_ready) begin
            rx_valid     <= 1'b0;
            parity_error <= 1'b0;
            frame_error  <= 1'b0;
            break_detect <= 1'b0;
            overrun      <= 1'b0;
        end
    end

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Self-checking bench for uart_rx_ctrl: table-driven frames with a scoreboard,
// plus hand sequences for break, glitch, stop-bit error, overrun and reset.
module tb_uart_rx_ctrl;

    logic       rx_clk = 1'b0;
    logic       resetn = 1'b0;
    logic       baud_tick = 1'b0;
    logic       rx_in = 1'b1;
    logic       parity_en = 1'b0;
    logic       parity_odd = 1'b0;
    logic       two_stop = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready = 1'b1;
    logic       parity_error, frame_error, break_detect, overrun, busy;

    int n_checks = 0;
    int n_fail   = 0;
    int tdiv     = 0;

    typedef struct packed {
        logic [7:0] data;
        logic       pe, fe, brk, ovr;
    } exp_t;

    typedef struct packed {
        logic [7:0] data;
        logic       pen, podd, pbit, two, s1, s2;
        logic       pe, fe, brk;
    } vec_t;

    exp_t exp_q[$];
    exp_t mon_e;
    vec_t vecs[11];

    uart_rx_ctrl dut (
        .rx_clk      (rx_clk),
        .resetn      (resetn),
        .baud_tick   (baud_tick),
        .rx_in       (rx_in),
        .parity_en   (parity_en),
        .parity_odd  (parity_odd),
        .two_stop    (two_stop),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .parity_error(parity_error),
        .frame_error (frame_error),
        .break_detect(break_detect),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 rx_clk = ~rx_clk;

    // One baud tick every 4 rx_clk cycles, changed on the inactive edge.
    always @(negedge rx_clk) begin
        tdiv      = (tdiv == 3) ? 0 : tdiv + 1;
        baud_tick = (tdiv == 0);
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted word is compared against the oldest expectation.
    always @(negedge rx_clk) begin
        if (resetn && rx_valid && rx_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_frame: got rx_data 0x%0h, expected no frame", rx_data);
            end else begin
                mon_e = exp_q.pop_front();
                check("sb_rx_data", 32'(rx_data), 32'(mon_e.data));
                check("sb_parity_error", 32'(parity_error), 32'(mon_e.pe));
                check("sb_frame_error", 32'(frame_error), 32'(mon_e.fe));
                check("sb_break_detect", 32'(break_detect), 32'(mon_e.brk));
                check("sb_overrun", 32'(overrun), 32'(mon_e.ovr));
            end
        end
    end

    task automatic tick_wait(input int n);
        repeat (n) begin
            @(posedge rx_clk);
            while (!baud_tick) @(posedge rx_clk);
        end
        #1;
    endtask

    task automatic send_bit(input logic b);
        rx_in = b;
        tick_wait(16);
    endtask

    // Framing pins are flipped after the start bit; the DUT must ignore the change.
    task automatic send_frame(input logic [7:0] d, input logic pen, input logic pbit,
                              input logic two, input logic s1, input logic s2);
        send_bit(1'b0);
        parity_en  = ~parity_en;
        parity_odd = ~parity_odd;
        two_stop   = ~two_stop;
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (pen) send_bit(pbit);
        send_bit(s1);
        if (two) send_bit(s2);
        parity_en  = ~parity_en;
        parity_odd = ~parity_odd;
        two_stop   = ~two_stop;
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 2000) begin
            @(posedge rx_clk);
            n++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        //                data    pen podd pbit two s1 s2   pe fe brk
        vecs[0]  = {8'hA5, 6'b0_0_0_0_1_1, 3'b0_0_0};
        vecs[1]  = {8'h07, 6'b1_0_0_0_1_1, 3'b1_0_0};
        vecs[2]  = {8'h07, 6'b1_0_1_0_1_1, 3'b0_0_0};
        vecs[3]  = {8'h07, 6'b1_1_0_0_1_1, 3'b0_0_0};
        vecs[4]  = {8'h07, 6'b1_1_1_0_1_1, 3'b1_0_0};
        vecs[5]  = {8'hFF, 6'b0_0_0_1_1_1, 3'b0_0_0};
        vecs[6]  = {8'h00, 6'b0_0_0_0_1_1, 3'b0_0_0};
        vecs[7]  = {8'h00, 6'b1_0_0_0_0_1, 3'b0_1_1};
        vecs[8]  = {8'h00, 6'b1_0_1_0_0_1, 3'b1_1_0};
        vecs[9]  = {8'h55, 6'b0_0_0_1_0_1, 3'b0_1_0};
        vecs[10] = {8'h3C, 6'b0_0_0_1_1_0, 3'b0_1_0};

        repeat (4) @(posedge rx_clk);
        #1;
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        resetn = 1'b1;
        tick_wait(4);
        check("post_rst_rx_data", 32'(rx_data), 32'd0);
        check("post_rst_flags", 32'({rx_valid, parity_error, frame_error, break_detect, overrun, busy}), 32'd0);

        for (int i = 0; i < 11; i++) begin
            parity_en  = vecs[i].pen;
            parity_odd = vecs[i].podd;
            two_stop   = vecs[i].two;
            exp_q.push_back('{data: vecs[i].data, pe: vecs[i].pe, fe: vecs[i].fe, brk: vecs[i].brk, ovr: 1'b0});
            send_frame(vecs[i].data, vecs[i].pen, vecs[i].pbit, vecs[i].two, vecs[i].s1, vecs[i].s2);
            rx_in = 1'b1;
            tick_wait(4);
            drain($sformatf("vec%0d_received", i));
            check($sformatf("vec%0d_idle", i), 32'(busy), 32'd0);
        end

        // Second stop bit low: frame error, then hold in WAIT_IDLE while the line stays low.
        parity_en = 1'b0; parity_odd = 1'b0; two_stop = 1'b1;
        exp_q.push_back('{data: 8'h3C, pe: 1'b0, fe: 1'b1, brk: 1'b0, ovr: 1'b0});
        send_frame(8'h3C, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        tick_wait(32);
        drain("stop2_low_received");
        check("wait_idle_busy", 32'(busy), 32'd1);
        rx_in = 1'b1;
        tick_wait(4);
        check("wait_idle_release", 32'(busy), 32'd0);

        // Break: line low for 20 bit times.
        two_stop = 1'b0;
        exp_q.push_back('{data: 8'h00, pe: 1'b0, fe: 1'b1, brk: 1'b1, ovr: 1'b0});
        rx_in = 1'b0;
        tick_wait(20 * 16);
        drain("break_received");
        check("break_busy", 32'(busy), 32'd1);
        rx_in = 1'b1;
        tick_wait(4);
        check("break_release_busy", 32'(busy), 32'd0);
        tick_wait(32);
        check("break_single_frame", 32'(rx_valid), 32'd0);

        // Glitch shorter than half a bit.
        rx_in = 1'b0;
        tick_wait(4);
        check("glitch_busy", 32'(busy), 32'd1);
        rx_in = 1'b1;
        tick_wait(20);
        check("glitch_rejected_busy", 32'(busy), 32'd0);
        check("glitch_no_valid", 32'(rx_valid), 32'd0);

        // Overrun: two frames back-to-back while the consumer stalls.
        rx_ready = 1'b0;
        exp_q.push_back('{data: 8'h11, pe: 1'b0, fe: 1'b0, brk: 1'b0, ovr: 1'b1});
        send_frame(8'h11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_frame(8'h22, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick_wait(4);
        check("ovr_valid_held", 32'(rx_valid), 32'd1);
        check("ovr_data_held", 32'(rx_data), 32'h11);
        check("ovr_flag", 32'(overrun), 32'd1);
        @(posedge rx_clk);
        #1;
        rx_ready = 1'b1;
        @(posedge rx_clk);
        #1;
        check("ovr_valid_cleared", 32'(rx_valid), 32'd0);
        check("ovr_flag_cleared", 32'(overrun), 32'd0);
        drain("ovr_received");

        // Reset in the middle of a frame with a word held.
        rx_ready = 1'b0;
        send_frame(8'h5A, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        send_bit(1'b0);
        send_bit(1'b1);
        check("pre_rst_valid", 32'(rx_valid), 32'd1);
        resetn = 1'b0;
        #1;
        check("mid_rst_rx_data", 32'(rx_data), 32'd0);
        check("mid_rst_flags", 32'({rx_valid, parity_error, frame_error, break_detect, overrun, busy}), 32'd0);
        rx_in = 1'b1;
        repeat (3) @(posedge rx_clk);
        #1;
        resetn   = 1'b1;
        rx_ready = 1'b1;
        tick_wait(40);
        check("after_rst_idle", 32'({rx_valid, busy}), 32'd0);
        check("sb_empty", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
